// File: rtl/epb_slave_pkg.sv
// Shared types and constants for the EPB slave controller.
// Used by epb_slave_ctrl (optional bus timeout under EPB_BUS_TIMEOUT_EN).
package epb_slave_pkg;

    localparam int EPB_DATA_W = 16;
    localparam int EPB_ADDR_W = 23;
    localparam int EPB_GP_W   = 6;

    localparam logic [EPB_DATA_W-1:0] EPB_TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } epb_state_e;

    // Internal bus address: general-purpose bits sit above the EPB address.
    function automatic logic [EPB_GP_W+EPB_ADDR_W-1:0] epb_addr_cat(
        input logic [EPB_GP_W-1:0]   gp,
        input logic [EPB_ADDR_W-1:0] addr
    );
        return {gp, addr};
    endfunction

endpackage

// File: rtl/epb_sync_bit.sv
// Multi-flop synchroniser for one asynchronous EPB strobe.
// Resets to 1 so that inactive (high) strobes look idle out of reset.
module epb_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/epb_slave_ctrl.sv
// EPB slave controller: strobe sync, request/ack sequencing, pad ready/data control.
// Optional request timeout enabled by defining EPB_BUS_TIMEOUT_EN.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a synchronised cs falling edge
//   REQ     | bus_req_o high, ready driven low, waiting for ack
//   RESP    | ready high; read data driven while oe is low
//   RELEASE | ready driven low for one cycle before tristating
module epb_slave_ctrl
    import epb_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024,
    parameter int ADDR_W      = 29
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  epb_cs_n,
    input  logic                  epb_oe_n,
    input  logic                  epb_r_w_n,
    input  logic [1:0]            epb_be_n,
    input  logic [EPB_ADDR_W-1:0] epb_addr,
    input  logic [EPB_GP_W-1:0]   epb_addr_gp,
    input  logic [EPB_DATA_W-1:0] epb_data_in_i,
    output logic [EPB_DATA_W-1:0] epb_data_out_o,
    output logic                  epb_data_oe_n_o,
    output logic                  epb_rdy_o,
    output logic                  epb_rdy_oe_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [1:0]            bus_be_o,
    output logic [EPB_DATA_W-1:0] bus_wdata_o,
    input  logic [EPB_DATA_W-1:0] bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic                  bus_err_o
);

    if (SYNC_STAGES < 2 || TIMEOUT < 2 || ADDR_W != EPB_GP_W + EPB_ADDR_W) begin : g_bad_param
        $error("epb_slave_ctrl: illegal parameter combination");
    end

    logic w_cs_s;
    logic w_oe_s;
    logic w_rw_s;

    epb_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_d(epb_cs_n), .o_q(w_cs_s)
    );
    epb_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_oe (
        .clk(clk), .rst_n(rst_n), .i_d(epb_oe_n), .o_q(w_oe_s)
    );
    epb_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rw (
        .clk(clk), .rst_n(rst_n), .i_d(epb_r_w_n), .o_q(w_rw_s)
    );

    epb_state_e             r_state;
    logic [SYNC_STAGES-1:0] r_settle;
    logic                   r_cs_prev;
    logic                   r_abort;
    logic                   r_we;
    logic [ADDR_W-1:0]      r_addr;
    logic [1:0]             r_be;
    logic [EPB_DATA_W-1:0]  r_wdata;
    logic [EPB_DATA_W-1:0]  r_dout;

    logic w_settled;
    logic w_cs_fall;
    logic w_release;

    // The edge detector only arms once the chain holds real samples, so a cs
    // held low across reset is not mistaken for a new falling edge.
    assign w_settled = r_settle[SYNC_STAGES-1];
    assign w_cs_fall = r_cs_prev & ~w_cs_s;
    assign w_release = r_abort | w_cs_s;

`ifdef EPB_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_tmo_cnt;
    logic            r_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_settle  <= '0;
            r_cs_prev <= 1'b0;
            r_abort   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_dout    <= '0;
`ifdef EPB_BUS_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_settle  <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            r_cs_prev <= w_settled & w_cs_s;
`ifdef EPB_BUS_TIMEOUT_EN
            r_err     <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_addr    <= epb_addr_cat(epb_addr_gp, epb_addr);
                        r_be      <= ~epb_be_n;
                        r_wdata   <= epb_data_in_i;
                        r_we      <= ~w_rw_s;
                        r_abort   <= 1'b0;
`ifdef EPB_BUS_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (w_cs_s) begin
                        r_abort <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        if (!r_we) begin
                            r_dout <= bus_rdata_i;
                        end
                        r_state <= w_release ? RELEASE : RESP;
                    end
`ifdef EPB_BUS_TIMEOUT_EN
                    else if (r_tmo_cnt == TO_LAST) begin
                        r_err <= 1'b1;
                        if (!r_we) begin
                            r_dout <= EPB_TIMEOUT_DATA;
                        end
                        r_state <= w_release ? RELEASE : RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (w_cs_s) begin
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus_req_o       = (r_state == REQ);
    assign bus_we_o        = r_we;
    assign bus_addr_o      = r_addr;
    assign bus_be_o        = r_be;
    assign bus_wdata_o     = r_wdata;
    assign epb_data_out_o  = r_dout;
    assign epb_rdy_o       = (r_state == RESP);
    assign epb_rdy_oe_o    = (r_state != IDLE);
    assign epb_data_oe_n_o = ~((r_state == RESP) & ~r_we & ~w_oe_s);

`ifdef EPB_BUS_TIMEOUT_EN
    assign bus_err_o = r_err;
`else
    assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_epb_slave_ctrl.sv
// Directed bench for epb_slave_ctrl: table-driven transactions plus abort,
// stall/timeout (EPB_BUS_TIMEOUT_EN), reset-mid-op and back-to-back sequences.
module tb_epb_slave_ctrl;
    import epb_slave_pkg::*;

    localparam int SS = 2;
    localparam int TO = 16;
    localparam int AW = 29;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        epb_cs_n = 1'b1;
    logic        epb_oe_n = 1'b1;
    logic        epb_r_w_n = 1'b1;
    logic [1:0]  epb_be_n = 2'b11;
    logic [22:0] epb_addr = '0;
    logic [5:0]  epb_addr_gp = '0;
    logic [15:0] epb_data_in_i = '0;
    logic [15:0] epb_data_out_o;
    logic        epb_data_oe_n_o;
    logic        epb_rdy_o;
    logic        epb_rdy_oe_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [AW-1:0] bus_addr_o;
    logic [1:0]  bus_be_o;
    logic [15:0] bus_wdata_o;
    logic [15:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        bus_err_o;

    always #5 clk = ~clk;

    epb_slave_ctrl #(.SYNC_STAGES(SS), .TIMEOUT(TO), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .epb_cs_n(epb_cs_n), .epb_oe_n(epb_oe_n), .epb_r_w_n(epb_r_w_n),
        .epb_be_n(epb_be_n), .epb_addr(epb_addr), .epb_addr_gp(epb_addr_gp),
        .epb_data_in_i(epb_data_in_i), .epb_data_out_o(epb_data_out_o),
        .epb_data_oe_n_o(epb_data_oe_n_o), .epb_rdy_o(epb_rdy_o),
        .epb_rdy_oe_o(epb_rdy_oe_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_dout = '0;

    // Request-rise monitor for back-to-back ordering.
    int          mon_rises = 0;
    logic        mon_prev = 1'b0;
    logic [15:0] mon_wd [8];
    always @(negedge clk) begin
        if (bus_req_o && !mon_prev) begin
            mon_wd[mon_rises % 8] = bus_wdata_o;
            mon_rises++;
        end
        mon_prev = bus_req_o;
    end

    typedef struct {
        logic        rw;
        logic [1:0]  be_n;
        logic [5:0]  gp;
        logic [22:0] addr;
        logic [15:0] data;
        logic [15:0] rdata;
        logic [28:0] e_addr;
        logic [1:0]  e_be;
        logic        e_we;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input logic rw, input logic [1:0] be_n, input logic [5:0] gp,
                             input logic [22:0] addr, input logic [15:0] data);
        epb_r_w_n     = rw;
        epb_be_n      = be_n;
        epb_addr_gp   = gp;
        epb_addr      = addr;
        epb_data_in_i = data;
        epb_oe_n      = 1'b1;
        epb_cs_n      = 1'b0;
    endtask

    task automatic wait_req(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus_req_o && n < bound);
    endtask

    task automatic ack_now(input logic [15:0] rdata);
        bus_rdata_i = rdata;
        bus_ack_i   = 1'b1;
        tick();
        bus_ack_i   = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int n;
        start_txn(v.rw, v.be_n, v.gp, v.addr, v.data);
        wait_req(20, n);
        chk({tag, "_req_latency"}, n, SS + 1);
        chk({tag, "_addr"}, bus_addr_o, v.e_addr);
        chk({tag, "_we"}, bus_we_o, v.e_we);
        chk({tag, "_be"}, bus_be_o, v.e_be);
        chk({tag, "_wdata"}, bus_wdata_o, v.data);
        repeat (3) tick();
        chk({tag, "_req_held"}, bus_req_o, 1'b1);
        ack_now(v.rdata);
        if (v.rw) exp_dout = v.rdata;
        chk({tag, "_resp_rdy"}, epb_rdy_o, 1'b1);
        chk({tag, "_resp_req_low"}, bus_req_o, 1'b0);
        chk({tag, "_resp_dout"}, epb_data_out_o, exp_dout);
        chk({tag, "_oe_n_before_oe"}, epb_data_oe_n_o, 1'b1);
        epb_oe_n = 1'b0;
        repeat (SS) tick();
        chk({tag, "_oe_n_during_oe"}, epb_data_oe_n_o, v.rw ? 1'b0 : 1'b1);
        epb_oe_n = 1'b1;
        epb_cs_n = 1'b1;
        repeat (SS) tick();
        chk({tag, "_oe_n_after_cs"}, epb_data_oe_n_o, 1'b1);
        chk({tag, "_rdy_until_cs_s"}, epb_rdy_o, 1'b1);
        tick();
        chk({tag, "_release_rdy"}, epb_rdy_o, 1'b0);
        chk({tag, "_release_rdy_oe"}, epb_rdy_oe_o, 1'b1);
        tick();
        chk({tag, "_idle_rdy_oe"}, epb_rdy_oe_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        logic seen_a;
        logic seen_b;

        vecs[0] = '{rw:1'b0, be_n:2'b00, gp:6'h01, addr:23'h000010, data:16'hA5A5,
                    rdata:16'h0000, e_addr:29'h0080_0010, e_be:2'b11, e_we:1'b1};
        vecs[1] = '{rw:1'b1, be_n:2'b01, gp:6'h3F, addr:23'h7FFFFF, data:16'h0F0F,
                    rdata:16'h1234, e_addr:29'h1FFF_FFFF, e_be:2'b10, e_we:1'b0};
        vecs[2] = '{rw:1'b0, be_n:2'b10, gp:6'h2A, addr:23'h155555, data:16'h5A0F,
                    rdata:16'hFFFF, e_addr:29'h1515_5555, e_be:2'b01, e_we:1'b1};
        vecs[3] = '{rw:1'b1, be_n:2'b11, gp:6'h00, addr:23'h000001, data:16'h0000,
                    rdata:16'hBEEF, e_addr:29'h0000_0001, e_be:2'b00, e_we:1'b0};

        // Reset values
        #12;
        chk("rst_data_oe_n", epb_data_oe_n_o, 1'b1);
        chk("rst_rdy", epb_rdy_o, 1'b0);
        chk("rst_rdy_oe", epb_rdy_oe_o, 1'b0);
        chk("rst_req", bus_req_o, 1'b0);
        chk("rst_err", bus_err_o, 1'b0);
        chk("rst_addr", bus_addr_o, 29'h0);
        chk("rst_be", bus_be_o, 2'b00);
        chk("rst_wdata", bus_wdata_o, 16'h0);
        chk("rst_dout", epb_data_out_o, 16'h0);
        chk("rst_we", bus_we_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            repeat (2) tick();
        end

        // Abort: cs rises during REQ, ack arrives 10 clocks later
        start_txn(1'b1, 2'b00, 6'h05, 23'h000100, 16'h0000);
        wait_req(20, n);
        chk("abort_req_latency", n, SS + 1);
        epb_oe_n = 1'b0;
        epb_cs_n = 1'b1;
        seen_a = 1'b0;
        seen_b = 1'b0;
        repeat (10) begin
            tick();
            if (epb_rdy_o) seen_a = 1'b1;
            if (!epb_data_oe_n_o) seen_b = 1'b1;
        end
        chk("abort_req_not_withdrawn", bus_req_o, 1'b1);
        ack_now(16'h7777);
        exp_dout = 16'h7777;
        chk("abort_release_rdy_oe", epb_rdy_oe_o, 1'b1);
        chk("abort_release_rdy", epb_rdy_o, 1'b0);
        chk("abort_release_req", bus_req_o, 1'b0);
        chk("abort_dout", epb_data_out_o, exp_dout);
        if (!epb_data_oe_n_o) seen_b = 1'b1;
        tick();
        chk("abort_idle_rdy_oe", epb_rdy_oe_o, 1'b0);
        repeat (4) begin
            if (epb_rdy_o) seen_a = 1'b1;
            if (!epb_data_oe_n_o) seen_b = 1'b1;
            tick();
        end
        chk("abort_rdy_never_high", seen_a, 1'b0);
        chk("abort_data_never_driven", seen_b, 1'b0);
        epb_oe_n = 1'b1;
        repeat (2) tick();

`ifdef EPB_BUS_TIMEOUT_EN
        // Timeout: no ack, request should last exactly TO cycles
        start_txn(1'b1, 2'b00, 6'h00, 23'h000200, 16'h0000);
        wait_req(20, n);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!bus_req_o) break;
            n++;
        end
        chk("tmo_req_cycles", n, TO);
        chk("tmo_err_pulse", bus_err_o, 1'b1);
        chk("tmo_dout", epb_data_out_o, 16'hDEAD);
        chk("tmo_rdy", epb_rdy_o, 1'b1);
        exp_dout = 16'hDEAD;
        tick();
        chk("tmo_err_one_cycle", bus_err_o, 1'b0);
        epb_cs_n = 1'b1;
        repeat (SS + 3) tick();
        chk("tmo_idle", epb_rdy_oe_o, 1'b0);
        // Ack on the terminal cycle wins
        start_txn(1'b1, 2'b00, 6'h00, 23'h000204, 16'h0000);
        wait_req(20, n);
        repeat (TO - 1) tick();
        chk("tmo_ack_req_still_high", bus_req_o, 1'b1);
        ack_now(16'h5678);
        exp_dout = 16'h5678;
        chk("tmo_ack_no_err", bus_err_o, 1'b0);
        chk("tmo_ack_dout", epb_data_out_o, exp_dout);
        chk("tmo_ack_rdy", epb_rdy_o, 1'b1);
        epb_cs_n = 1'b1;
        repeat (SS + 3) tick();
`else
        // Without the timeout, a stalled request waits indefinitely
        start_txn(1'b1, 2'b00, 6'h00, 23'h000200, 16'h0000);
        wait_req(20, n);
        seen_a = 1'b0;
        seen_b = 1'b0;
        repeat (40) begin
            tick();
            if (!bus_req_o) seen_a = 1'b1;
            if (bus_err_o) seen_b = 1'b1;
        end
        chk("stall_req_never_dropped", seen_a, 1'b0);
        chk("stall_no_err", seen_b, 1'b0);
        ack_now(16'h4242);
        exp_dout = 16'h4242;
        chk("stall_dout", epb_data_out_o, exp_dout);
        chk("stall_rdy", epb_rdy_o, 1'b1);
        epb_cs_n = 1'b1;
        repeat (SS + 3) tick();
        chk("stall_idle", epb_rdy_oe_o, 1'b0);
`endif

        // Reset mid-operation while driving read data
        start_txn(1'b1, 2'b00, 6'h07, 23'h000300, 16'h0000);
        wait_req(20, n);
        ack_now(16'h9999);
        epb_oe_n = 1'b0;
        repeat (SS) tick();
        chk("rstmid_driving", epb_data_oe_n_o, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_data_oe_n", epb_data_oe_n_o, 1'b1);
        chk("rstmid_rdy_oe", epb_rdy_oe_o, 1'b0);
        chk("rstmid_req", bus_req_o, 1'b0);
        chk("rstmid_dout", epb_data_out_o, 16'h0);
        exp_dout = 16'h0;
        epb_oe_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        seen_a = 1'b0;
        repeat (12) begin
            tick();
            if (bus_req_o) seen_a = 1'b1;
        end
        chk("rstmid_no_spurious_req", seen_a, 1'b0);
        epb_cs_n = 1'b1;
        repeat (SS + 2) tick();
        start_txn(1'b0, 2'b00, 6'h01, 23'h000008, 16'hC3C3);
        wait_req(20, n);
        chk("rstmid_rearm_latency", n, SS + 1);
        chk("rstmid_rearm_wdata", bus_wdata_o, 16'hC3C3);
        ack_now(16'h0000);
        epb_cs_n = 1'b1;
        repeat (SS + 3) tick();

        // Back-to-back, 1-clock cs high gap: second edge is filtered
        base = mon_rises;
        start_txn(1'b0, 2'b00, 6'h01, 23'h000020, 16'h1111);
        wait_req(20, n);
        ack_now(16'h0000);
        epb_cs_n = 1'b1;
        tick();
        start_txn(1'b0, 2'b00, 6'h01, 23'h000024, 16'h2222);
        repeat (20) begin
            tick();
            if (bus_req_o) ack_now(16'h0000);
        end
        epb_cs_n = 1'b1;
        repeat (SS + 4) tick();
        chk("b2b_short_gap_requests", mon_rises - base, 1);
        chk("b2b_short_gap_first_wdata", mon_wd[base % 8], 16'h1111);

        // Back-to-back, SYNC_STAGES+2 clock gap: both writes seen in order
        base = mon_rises;
        start_txn(1'b0, 2'b00, 6'h02, 23'h000030, 16'h3333);
        wait_req(20, n);
        ack_now(16'h0000);
        epb_cs_n = 1'b1;
        repeat (SS + 2) tick();
        start_txn(1'b0, 2'b01, 6'h03, 23'h000034, 16'h4444);
        wait_req(20, n);
        chk("b2b_second_req", bus_req_o, 1'b1);
        chk("b2b_second_addr", bus_addr_o, 29'h0180_0034);
        chk("b2b_second_be", bus_be_o, 2'b10);
        ack_now(16'h0000);
        epb_cs_n = 1'b1;
        repeat (SS + 4) tick();
        chk("b2b_long_gap_requests", mon_rises - base, 2);
        chk("b2b_order_first", mon_wd[base % 8], 16'h3333);
        chk("b2b_order_second", mon_wd[(base + 1) % 8], 16'h4444);
        chk("final_dout_unchanged", epb_data_out_o, exp_dout);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
